// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with valid/ready handshake and iterative MUL/DIVU/REMU
// Ports: clk_i/rst_i clock and sync active-high reset; valid_i/ready_o request handshake;
//        data1_i/data2_i operands, ALUCtrl_i op select; valid_o one-cycle result strobe;
//        data_o registered result; Zero_o registered all-zero flag of data_o.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [3:0]       ALUCtrl_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [3:0] OP_AND = 4'h0, OP_XOR = 4'h1, OP_SLL = 4'h2, OP_ADD = 4'h3,
                           OP_SUB = 4'h4, OP_MUL = 4'h5, OP_ADDI = 4'h6, OP_SRA = 4'h7,
                           OP_OR = 4'h8, OP_SRL = 4'h9, OP_SLT = 4'hA, OP_SLTU = 4'hB,
                           OP_DIVU = 4'hC, OP_REMU = 4'hD;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    state_t           state, state_n;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] a, b, acc, alu_res, res_n, mul_acc, div_rem, div_quo;
    logic [WIDTH:0]   div_diff;
    logic [SHW-1:0]   sh;
    logic             rem_op, last, load, is_mul, is_div, div_ge;
    assign ready_o = state == S_IDLE;
    assign sh      = data2_i[SHW-1:0];
    assign is_mul  = ALUCtrl_i == OP_MUL;
    assign is_div  = ALUCtrl_i == OP_DIVU || ALUCtrl_i == OP_REMU;
    assign last    = cnt == SHW'(WIDTH - 1);
    // multiplier: a is the shifting multiplicand, b the shifting multiplier, acc the partial product
    assign mul_acc = b[0] ? acc + a : acc;
    // restoring divider: a shifts the dividend out and the quotient bits in, acc holds the remainder
    assign div_diff = {acc, a[WIDTH-1]} - {1'b0, b};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : {acc[WIDTH-2:0], a[WIDTH-1]};
    assign div_quo  = {a[WIDTH-2:0], div_ge};
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND:         alu_res = data1_i & data2_i;
            OP_XOR:         alu_res = data1_i ^ data2_i;
            OP_SLL:         alu_res = data1_i << sh;
            OP_ADD, OP_ADDI: alu_res = data1_i + data2_i;
            OP_SUB:         alu_res = data1_i - data2_i;
            OP_SRA:         alu_res = $signed(data1_i) >>> sh;
            OP_OR:          alu_res = data1_i | data2_i;
            OP_SRL:         alu_res = data1_i >> sh;
            OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, $signed(data1_i) < $signed(data2_i)};
            OP_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, data1_i < data2_i};
            default:        alu_res = '0;
        endcase
    end
    always_comb begin
        state_n = state;
        load    = 1'b0;
        res_n   = alu_res;
        case (state)
            S_IDLE: begin
                load    = valid_i && !is_mul && !is_div;
                state_n = !valid_i ? S_IDLE : is_mul ? S_MUL : is_div ? S_DIV : S_IDLE;
            end
            S_MUL: begin
                load    = last;
                res_n   = mul_acc;
                state_n = last ? S_IDLE : S_MUL;
            end
            S_DIV: begin
                load    = last;
                res_n   = rem_op ? div_rem : div_quo;
                state_n = last ? S_IDLE : S_DIV;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        state <= rst_i ? S_IDLE : state_n;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            Zero_o  <= 1'b1;
            cnt     <= '0;
            a       <= '0;
            b       <= '0;
            acc     <= '0;
            rem_op  <= 1'b0;
        end else begin
            valid_o <= load;
            if (load) begin
                data_o <= res_n;
                Zero_o <= res_n == '0;
            end
            if (state == S_IDLE) begin
                if (valid_i && (is_mul || is_div)) begin
                    cnt    <= '0;
                    a      <= data1_i;
                    b      <= data2_i;
                    acc    <= '0;
                    rem_op <= ALUCtrl_i[0];
                end
            end else if (state == S_MUL) begin
                acc <= mul_acc;
                a   <= a << 1;
                b   <= b >> 1;
                cnt <= cnt + SHW'(1);
            end else begin
                acc <= div_rem;
                a   <= div_quo;
                cnt <= cnt + SHW'(1);
            end
        end
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle execute-stage ALU.
- Adds a valid/ready handshake, a registered result, a real Zero flag, extra ops (OR, SRL, SLT, SLTU), and iterative multi-cycle MUL, DIVU and REMU.
- Sits in the EX stage. The hazard unit stalls the pipeline while ready_o is low.

Parameters:
- WIDTH, 32, datapath width. Must be a power of two, ≥8.
- SHW, $clog2(WIDTH), shift-amount width. Derived localparam; not overridable.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operation request.
- ready_o  output  1  block can accept a request this cycle.
- data1_i  input  WIDTH  operand A; treated as signed where the op requires it.
- data2_i  input  WIDTH  operand B or immediate.
- ALUCtrl_i  input  4  op select.
- valid_o  output  1  one-cycle pulse; data_o and Zero_o are valid in that cycle.
- data_o  output  WIDTH  registered result.
- Zero_o  output  1  registered; 1 iff the result is all-zero.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE, valid_o=0, data_o=0, Zero_o=1, ready_o=1.
  - Clears the iteration counter and working registers.
  - Overrides any in-flight operation; the result is discarded and no valid_o is produced.
- Accept condition: valid_i && ready_o at a clock edge. Operands and op are captured only then.
- ready_o is combinational: 1 iff state==IDLE.
- Op codes:
  - 0000 AND; 0001 XOR; 0010 SLL; 0011 ADD; 0100 SUB; 0101 MUL; 0110 ADDI (same as ADD); 0111 SRA.
  - 1000 OR; 1001 SRL; 1010 SLT (signed, result 0/1); 1011 SLTU (result 0/1); 1100 DIVU; 1101 REMU.
  - 1110 and 1111 are reserved: result 0, single-cycle.
- Shift ops (SLL, SRL, SRA) use only data2_i[SHW-1:0]. SRA is arithmetic.
- ADD/SUB/MUL wrap modulo 2^WIDTH. No overflow flag.
- Single-cycle ops:
  - Result registered on the accept edge; valid_o=1 in the following cycle.
  - State stays IDLE, so back-to-back accepts every cycle give one valid_o per cycle.
- MUL:
  - Radix-2 shift-add over WIDTH iterations; returns the low WIDTH bits of the product (sign-agnostic).
  - Accept edge moves state IDLE->MUL with counter=0. One iteration per cycle.
  - After iteration WIDTH-1: result loads into data_o and state returns to IDLE.
  - valid_o pulses in the next cycle, which is WIDTH+1 cycles after the accept edge.
  - ready_o is 0 for WIDTH cycles.
- DIVU/REMU:
  - Unsigned restoring divider. Same state shape (state DIV) and same latency as MUL.
  - DIVU returns the quotient; REMU returns the remainder.
  - Divide-by-zero: quotient = all ones, remainder = data1_i. Still takes the full latency.
- valid_o:
  - High for exactly one cycle per accepted op; results are in accept order.
  - data_o and Zero_o hold their last value until the next result loads.
- valid_i while ready_o=0 is ignored. The requester must hold it until it sees ready_o=1.
- A request presented in the same cycle as a multi-cycle op's valid_o pulse is accepted, because state is already IDLE.
- A single-cycle op's result never overtakes an in-flight multi-cycle result, since no accept is possible while busy.

Test Plan:
- Reset mid-MUL: accept MUL 3*5, assert rst_i at cycle 4 -> valid_o never pulses; data_o=0, Zero_o=1, ready_o=1 the cycle after reset.
- Back-to-back single-cycle ops, WIDTH=32, one per cycle: ADD 7+(-9), SUB 5-5, SRA 0x80000000>>>4, SLTU 1<0xFFFFFFFF -> valid_o high 4 consecutive cycles with data_o = 0xFFFFFFFE (Z=0), 0x00000000 (Z=1), 0xF8000000, 0x00000001.
- MUL 0xFFFFFFFF * 0x00000003 -> ready_o low 32 cycles; valid_o at cycle 33 after accept; data_o=0xFFFFFFFD.
- DIVU 100/7 then REMU 100/7 back-to-back, with valid_i held high during busy -> data_o=14, then 2; second accept occurs on the first-result valid_o cycle.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234; both after full latency.
- WIDTH=8 instance: SLL 0x01 by data2_i=0x09 (only 3 bits used) -> 0x02; MUL 0x10*0x10 -> 0x00 with Zero_o=1 after 9 cycles.
